// File: rtl/f_adder_seq.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit slice, LSB nibble first, valid/ready on both sides.
// Optional subtract mode (A - B - borrow) is enabled by defining F_ADDER_SEQ_SUB_EN.
module f_adder_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             cin,
`ifdef F_ADDER_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sout,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned SW  = CW + 2;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CW-1:0]    idx;
  logic [SW-1:0]    shamt;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       slice;
`ifdef F_ADDER_SEQ_SUB_EN
  logic             sub_r;
`endif

  // Shared 4-bit slice operating on the nibble selected by idx
  assign shamt = {idx, 2'b00};
  assign a_nib = a_r[shamt +: 4];
`ifdef F_ADDER_SEQ_SUB_EN
  assign b_nib = b_r[shamt +: 4] ^ {4{sub_r}};
`else
  assign b_nib = b_r[shamt +: 4];
`endif
  assign slice = {1'b0, a_nib} + {1'b0, b_nib} + 5'(carry_r);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sout      <= '0;
      cout      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      carry_r   <= 1'b0;
      idx       <= '0;
`ifdef F_ADDER_SEQ_SUB_EN
      sub_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= ain;
            b_r      <= bin;
`ifdef F_ADDER_SEQ_SUB_EN
            sub_r    <= sub;
            carry_r  <= cin ^ sub;
`else
            carry_r  <= cin;
`endif
            idx      <= '0;
            sout     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sout[shamt +: 4] <= slice[3:0];
          carry_r          <= slice[4];
          if (idx == LAST) begin
            cout      <= slice[4];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + CW'(1);
          end
        end
        DONE: begin
          // Handoff edge never accepts; IDLE opens one cycle later
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
